// File: rtl/sprite_reg_sequencer_if.sv
// Host register-write bus and renderer write bus of the sprite register sequencer.
// The sequencer drives the renderer side through the slave modport; the host drives the master modport.
interface sprite_reg_sequencer_if #(
    parameter int OUT_AW = 9
);
    logic              host_chipselect;
    logic              host_write;
    logic [3:0]        host_address;
    logic [31:0]       host_writedata;

    logic              out_chipselect;
    logic              out_write;
    logic [OUT_AW-1:0] out_address;
    logic [31:0]       out_writedata;

    modport master (
        output host_chipselect, host_write, host_address, host_writedata,
        input  out_chipselect, out_write, out_address, out_writedata
    );

    modport slave (
        input  host_chipselect, host_write, host_address, host_writedata,
        output out_chipselect, out_write, out_address, out_writedata
    );
endinterface

// File: rtl/sprite_reg_sequencer.sv
// Shadows NREGS renderer registers and, on each vga_vs falling edge, replays the dirty ones as one write per cycle.
// Optional macro SPRITE_SEQ_FORCE_REFRESH_EN: every commit rewrites all registers regardless of dirty state.
module sprite_reg_sequencer #(
    parameter int NREGS  = 13,
    parameter int OUT_AW = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sprite_reg_sequencer_if.slave  bus,
    input  logic                   vga_vs,
    output logic                   busy,
    output logic                   overrun
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    logic             vs_r;
    logic [IW-1:0]    idx_r;
    logic [7:0]       shadow_r [NREGS];
    logic [7:0]       commit_r [NREGS];
    logic [NREGS-1:0] dirty_r;
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] wr_hit_s;
    logic             commit_evt_s;
    logic             take_s;
    logic             unused_s;

    // Commit-event detection and per-register host write decode.
    always_comb begin
        commit_evt_s = vs_r & ~vga_vs;
        take_s       = commit_evt_s & (state_r == IDLE);
        unused_s     = ^bus.host_writedata[31:8];
        for (int i = 0; i < NREGS; i++) begin
            wr_hit_s[i] = bus.host_chipselect & bus.host_write
                        & ({28'd0, bus.host_address} == 32'(i));
        end
    end

    // Shadow bank and dirty mask; a write landing on the commit edge stays dirty for the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_r[i] <= 8'd0;
            end
            dirty_r <= {NREGS{1'b1}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_hit_s[i]) begin
                    shadow_r[i] <= bus.host_writedata[7:0];
                end
            end
            dirty_r <= (take_s ? {NREGS{1'b0}} : dirty_r) | wr_hit_s;
        end
    end

    // Commit FSM: snapshot on the event, then one registered renderer slot per index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r            <= IDLE;
            idx_r              <= {IW{1'b0}};
            vs_r               <= 1'b1;
            pending_r          <= {NREGS{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                commit_r[i] <= 8'd0;
            end
            bus.out_write      <= 1'b0;
            bus.out_chipselect <= 1'b0;
            bus.out_address    <= {OUT_AW{1'b0}};
            bus.out_writedata  <= 32'd0;
            busy               <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            vs_r <= vga_vs;
            busy <= (state_r == SCAN);
            case (state_r)
                IDLE: begin
                    bus.out_write      <= 1'b0;
                    bus.out_chipselect <= 1'b0;
                    if (take_s) begin
                        for (int i = 0; i < NREGS; i++) begin
                            commit_r[i] <= shadow_r[i];
                        end
`ifdef SPRITE_SEQ_FORCE_REFRESH_EN
                        pending_r <= {NREGS{1'b1}};
`else
                        pending_r <= dirty_r;
`endif
                        idx_r   <= {IW{1'b0}};
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    if (commit_evt_s) begin
                        overrun <= 1'b1;
                    end
                    bus.out_write      <= pending_r[idx_r];
                    bus.out_chipselect <= pending_r[idx_r];
                    // Skipped slots keep the last address/data on the bus.
                    if (pending_r[idx_r]) begin
                        bus.out_address   <= OUT_AW'(idx_r);
                        bus.out_writedata <= {24'd0, commit_r[idx_r]};
                    end
                    if (idx_r == IW'(NREGS - 1)) begin
                        idx_r   <= {IW{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_reg_sequencer.sv
// Randomized and directed bench for sprite_reg_sequencer against a frame-level reference model.
// Honors SPRITE_SEQ_FORCE_REFRESH_EN the same way the design does.
module tb_sprite_reg_sequencer;

    localparam int NREGS  = 13;
    localparam int OUT_AW = 9;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic vga_vs  = 1'b1;
    logic busy;
    logic overrun;

    sprite_reg_sequencer_if #(.OUT_AW(OUT_AW)) bus ();

    sprite_reg_sequencer #(.NREGS(NREGS), .OUT_AW(OUT_AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .vga_vs  (vga_vs),
        .busy    (busy),
        .overrun (overrun)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: frame snapshot and scan window expressed in absolute edge numbers.
    logic [7:0] m_shadow [NREGS];
    logic [7:0] m_commit [NREGS];
    bit         m_dirty  [NREGS];
    bit         m_pend   [NREGS];
    bit         m_active;
    int         m_start;
    int         cyc = 0;
    bit         m_vs_prev;
    bit         m_overrun;
    bit         exp_write;
    bit         exp_busy;
    int         m_addr;
    logic [7:0] m_data;
    int         pulses = 0;
    int         busy_cnt = 0;

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_shadow[i] = 8'd0; m_commit[i] = 8'd0; m_dirty[i] = 1'b1; m_pend[i] = 1'b0;
        end
        m_active = 1'b0; m_start = 0; m_vs_prev = 1'b1; m_overrun = 1'b0;
        exp_write = 1'b0; exp_busy = 1'b0; m_addr = 0; m_data = 8'd0;
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            cyc++;
            if (m_vs_prev && !vga_vs) begin
                if (m_active && cyc <= m_start + NREGS) begin
                    m_overrun = 1'b1;
                end else begin
                    for (int i = 0; i < NREGS; i++) begin
                        m_commit[i] = m_shadow[i];
`ifdef SPRITE_SEQ_FORCE_REFRESH_EN
                        m_pend[i] = 1'b1;
`else
                        m_pend[i] = m_dirty[i];
`endif
                        m_dirty[i] = 1'b0;
                    end
                    m_active = 1'b1;
                    m_start  = cyc;
                end
            end
            m_vs_prev = vga_vs;
            if (bus.host_chipselect && bus.host_write && int'(bus.host_address) < NREGS) begin
                m_shadow[int'(bus.host_address)] = bus.host_writedata[7:0];
                m_dirty[int'(bus.host_address)]  = 1'b1;
            end
            if (m_active && cyc >= m_start + 1 && cyc <= m_start + NREGS) begin
                exp_busy  = 1'b1;
                exp_write = m_pend[cyc - m_start - 1];
                if (exp_write) begin
                    m_addr = cyc - m_start - 1;
                    m_data = m_commit[m_addr];
                end
            end else begin
                exp_busy  = 1'b0;
                exp_write = 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) model_reset();
        check_val("out_write",      32'(bus.out_write),      32'(exp_write));
        check_val("out_chipselect", 32'(bus.out_chipselect), 32'(exp_write));
        check_val("out_address",    32'(bus.out_address),    32'(m_addr));
        check_val("out_writedata",  bus.out_writedata,       {24'd0, m_data});
        check_val("busy",           32'(busy),               32'(exp_busy));
        check_val("overrun",        32'(overrun),            32'(m_overrun));
        if (bus.out_write) pulses++;
        if (busy) busy_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
        bus.host_chipselect = 1'b1; bus.host_write = 1'b1;
        bus.host_address = a; bus.host_writedata = d;
        tick();
        bus.host_chipselect = 1'b0; bus.host_write = 1'b0;
    endtask

    task automatic vsync_fall();
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
    endtask

    task automatic clear_counts();
        pulses = 0; busy_cnt = 0;
    endtask

`ifdef SPRITE_SEQ_FORCE_REFRESH_EN
    localparam int FULL = 1;
`else
    localparam int FULL = 0;
`endif

    initial begin
        bus.host_chipselect = 1'b0; bus.host_write = 1'b0;
        bus.host_address = 4'd0; bus.host_writedata = 32'd0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // First commit after reset pushes everything.
        clear_counts();
        vsync_fall();
        tick(NREGS + 3);
        check_val("first_scan_pulses", 32'(pulses), 32'(NREGS));
        check_val("first_scan_busy",   32'(busy_cnt), 32'(NREGS));

        // Two dirty registers.
        host_wr(4'd3, 32'h0000_005A);
        host_wr(4'd10, 32'hFFFF_FF07);
        clear_counts();
        vsync_fall();
        tick(NREGS + 3);
        check_val("two_dirty_pulses", 32'(pulses), FULL ? 32'(NREGS) : 32'd2);

        // Write coinciding with the commit edge.
        clear_counts();
        vga_vs = 1'b0;
        bus.host_chipselect = 1'b1; bus.host_write = 1'b1;
        bus.host_address = 4'd5; bus.host_writedata = 32'h0000_0033;
        tick();
        bus.host_chipselect = 1'b0; bus.host_write = 1'b0;
        vga_vs = 1'b1;
        tick(NREGS + 3);
        check_val("coincide_pulses", 32'(pulses), FULL ? 32'(NREGS) : 32'd0);
        clear_counts();
        vsync_fall();
        tick(NREGS + 3);
        check_val("coincide_next_pulses", 32'(pulses), FULL ? 32'(NREGS) : 32'd1);

        // Second edge during a scan.
        clear_counts();
        vsync_fall();
        tick(4);
        vsync_fall();
        tick(NREGS + 3);
        check_val("overrun_sticky", 32'(overrun), 32'd1);
        check_val("overrun_busy",   32'(busy_cnt), 32'(NREGS));

        // Out-of-range index is ignored.
        host_wr(4'd14, 32'h0000_00AA);
        clear_counts();
        vsync_fall();
        tick(NREGS + 3);
        check_val("oob_pulses", 32'(pulses), FULL ? 32'(NREGS) : 32'd0);

        // Random host traffic and vsync activity.
        for (int c = 0; c < 800; c++) begin
            bus.host_chipselect = ($urandom_range(0, 3) != 0);
            bus.host_write      = ($urandom_range(0, 2) != 0);
            bus.host_address    = 4'($urandom_range(0, 15));
            bus.host_writedata  = $urandom;
            vga_vs              = ($urandom_range(0, 11) != 0);
            tick();
        end
        bus.host_chipselect = 1'b0; bus.host_write = 1'b0; vga_vs = 1'b1;
        tick(NREGS + 3);

        // Reset in the middle of a scan.
        host_wr(4'd7, 32'h0000_00C3);
        vsync_fall();
        tick(5);
        reset_n = 1'b0;
        clear_counts();
        tick(3);
        check_val("reset_abort_pulses", 32'(pulses), 32'd0);
        check_val("reset_overrun",      32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick(2);
        clear_counts();
        vsync_fall();
        tick(NREGS + 3);
        check_val("post_reset_pulses", 32'(pulses), 32'(NREGS));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
